rs_decode_ctrl: RTL and testbench

RS_DECODE_CTRL -- requirements
Module: rs_decode_ctrl

---
 rtl/rs_decode_ctrl.sv | 143 ++++++++++++++
 tb/tb_rs_decode_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decode_ctrl.sv
// Frame-level sequencer for an RS decoder: symbol collection, BM wait with timeout, Chien sweep.
// One FSM register plus sym/wait/chien/frame counters; pulses (scalc_done, frame_err) are registered.
module rs_decode_ctrl #(
    parameter int N          = 255,
    parameter int T          = 8,
    parameter int BM_TIMEOUT = 24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sym_valid,
    input  logic        sym_first,
    output logic        in_ready,
    output logic        scalc_done,
    input  logic        BM_done,
    output logic        chien_en,
    output logic [7:0]  chien_cnt,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(N + 1);
    localparam int WW = $clog2(BM_TIMEOUT + 1);

    // A code needs room for 2T parity symbols, and the sweep index leaves on 8 bits.
    generate
        if (N <= 2 * T || N > 256) begin : g_bad_params
            $error("rs_decode_ctrl: N must exceed 2*T and fit the 8-bit chien_cnt");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_BM_WAIT,
        S_CHIEN,
        S_DONE
    } state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] sym_q, sym_nxt;
    logic [WW-1:0] wait_q, wait_nxt;
    logic [CW-1:0] chien_q, chien_nxt;
    logic [15:0]   fcnt_q, fcnt_nxt;
    logic          scalc_q, scalc_nxt;
    logic          err_q, err_nxt;
    logic          accept;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            sym_q   <= '0;
            wait_q  <= '0;
            chien_q <= '0;
            fcnt_q  <= '0;
            scalc_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sym_q   <= sym_nxt;
            wait_q  <= wait_nxt;
            chien_q <= chien_nxt;
            fcnt_q  <= fcnt_nxt;
            scalc_q <= scalc_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        sym_nxt    = sym_q;
        wait_nxt   = wait_q;
        chien_nxt  = chien_q;
        fcnt_nxt   = fcnt_q;
        scalc_nxt  = 1'b0;
        err_nxt    = 1'b0;
        in_ready   = (state_q == S_IDLE) || (state_q == S_COLLECT);
        busy       = (state_q != S_IDLE);
        chien_en   = (state_q == S_CHIEN);
        frame_done = (state_q == S_DONE);
        accept     = sym_valid & in_ready;

        case (state_q)
            S_IDLE: begin
                if (accept && sym_first) begin
                    sym_nxt   = CW'(1);
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (sym_first) begin
                        sym_nxt = CW'(1);
                        err_nxt = 1'b1;
                    end else if (sym_q == CW'(N - 1)) begin
                        sym_nxt   = '0;
                        wait_nxt  = '0;
                        scalc_nxt = 1'b1;
                        state_nxt = S_BM_WAIT;
                    end else begin
                        sym_nxt = sym_q + CW'(1);
                    end
                end
            end
            S_BM_WAIT: begin
                // BM_done wins over a timeout landing in the same cycle.
                if (BM_done) begin
                    wait_nxt  = '0;
                    chien_nxt = '0;
                    state_nxt = S_CHIEN;
                end else if (wait_q == WW'(BM_TIMEOUT - 1)) begin
                    wait_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wait_nxt = wait_q + WW'(1);
                end
            end
            S_CHIEN: begin
                if (chien_q == CW'(N - 1)) begin
                    chien_nxt = '0;
                    fcnt_nxt  = fcnt_q + 16'd1;
                    state_nxt = S_DONE;
                end else begin
                    chien_nxt = chien_q + CW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign scalc_done = scalc_q;
    assign frame_err  = err_q;
    assign frame_cnt  = fcnt_q;
    assign chien_cnt  = chien_en ? 8'(chien_q) : 8'd0;

endmodule

// File: tb/tb_rs_decode_ctrl.sv
// Randomized and directed bench for rs_decode_ctrl against a timestamp-based frame model.
module tb_rs_decode_ctrl;

    localparam int N          = 255;
    localparam int T          = 8;
    localparam int BM_TIMEOUT = 24;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_first = 1'b0;
    logic        BM_done = 1'b0;
    logic        in_ready, scalc_done, chien_en, frame_done, frame_err, busy;
    logic [7:0]  chien_cnt;
    logic [15:0] frame_cnt;

    rs_decode_ctrl #(.N(N), .T(T), .BM_TIMEOUT(BM_TIMEOUT)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .sym_valid  (sym_valid),
        .sym_first  (sym_first),
        .in_ready   (in_ready),
        .scalc_done (scalc_done),
        .BM_done    (BM_done),
        .chien_en   (chien_en),
        .chien_cnt  (chien_cnt),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    initial forever #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Model: 0 = taking symbols, 1 = syndromes out / awaiting BM, 2 = evaluation sweep and completion.
    int          t = 0;
    int          m_phase = 0;
    int          m_n = 0;
    int          t_sc = 0;
    int          t_ch = 0;
    logic [15:0] m_fcnt = '0;
    logic        m_err = 1'b0;

    // Stimulus policy.
    int vpct = 0;
    bit tog = 1'b0;
    bit auto_first = 1'b0;
    int resync_at = 0;
    int bm_delay = 1000;
    bit stray = 1'b0;
    int rnd_resync = 0;

    int n_sc, n_fd, n_fe, n_ce, max_cc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic clear_obs();
        n_sc = 0; n_fd = 0; n_fe = 0; n_ce = 0; max_cc = 0;
    endtask

    task automatic model_edge(input logic v, input logic f, input logic bm, input logic rst);
        m_err = 1'b0;
        if (rst) begin
            m_phase = 0; m_n = 0; m_fcnt = '0;
        end else if (m_phase == 0) begin
            if (v && f) begin
                if (m_n != 0) m_err = 1'b1;
                m_n = 1;
            end else if (v && m_n != 0) begin
                m_n++;
                if (m_n == N) begin
                    m_phase = 1; t_sc = t; m_n = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (bm) begin
                m_phase = 2; t_ch = t;
            end else if (t - t_sc == BM_TIMEOUT) begin
                m_err = 1'b1; m_phase = 0;
            end
        end else begin
            if (t == t_ch + N) m_fcnt = m_fcnt + 16'd1;
            else if (t == t_ch + N + 1) m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        logic ce;
        ce = (m_phase == 2) && (t < t_ch + N);
        if (scalc_done === 1'b1) n_sc++;
        if (frame_done === 1'b1) n_fd++;
        if (frame_err === 1'b1) n_fe++;
        if (chien_en === 1'b1) n_ce++;
        if (chien_en === 1'b1 && int'(chien_cnt) > max_cc) max_cc = int'(chien_cnt);
        chk("in_ready",   16'(in_ready),   16'(m_phase == 0));
        chk("busy",       16'(busy),       16'((m_phase != 0) || (m_n != 0)));
        chk("scalc_done", 16'(scalc_done), 16'((m_phase == 1) && (t == t_sc)));
        chk("chien_en",   16'(chien_en),   16'(ce));
        chk("chien_cnt",  16'(chien_cnt),  ce ? 16'(t - t_ch) : 16'd0);
        chk("frame_done", 16'(frame_done), 16'((m_phase == 2) && (t == t_ch + N)));
        chk("frame_err",  16'(frame_err),  16'(m_err));
        chk("frame_cnt",  frame_cnt,       m_fcnt);
    endtask

    task automatic step(input logic v, input logic f, input logic bm, input logic rst);
        sym_valid = v; sym_first = f; BM_done = bm; rst_in = rst;
        @(posedge clk_in);
        t++;
        model_edge(v, f, bm, rst);
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            logic v, f, bm;
            v  = tog ? (i % 2 == 0) : ($urandom_range(99) < vpct);
            f  = 1'b0;
            bm = 1'b0;
            if (m_phase == 0 && m_n == 0) begin
                f = auto_first;
            end else if (m_phase == 0 && v && resync_at != 0 && m_n + 1 == resync_at) begin
                f = 1'b1; resync_at = 0;
            end else if (m_phase == 0 && rnd_resync != 0) begin
                f = ($urandom_range(rnd_resync - 1) == 0);
            end
            if (m_phase == 1) bm = (t - t_sc == bm_delay);
            else if (stray) bm = ($urandom_range(9) == 0);
            step(v, f, bm, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] fc_before;
        bit hit;
        clear_obs();

        // Reset and idle outputs.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_frame_cnt", frame_cnt, 16'd0);

        // Stray inputs while idle: unflagged symbols and BM_done pulses.
        vpct = 70; stray = 1'b1; auto_first = 1'b0;
        run(40);
        chk("stray_busy", 16'(busy), 16'd0);
        chk("stray_pulses", 16'(n_sc + n_fd + n_fe + n_ce), 16'd0);

        // Nominal frame, BM_done 17 cycles after scalc_done.
        clear_obs();
        stray = 1'b0; vpct = 100; auto_first = 1'b1; bm_delay = 17;
        run(N);
        vpct = 0; auto_first = 1'b0;
        run(300);
        chk("nom_scalc_cnt", 16'(n_sc), 16'd1);
        chk("nom_chien_len", 16'(n_ce), 16'(N));
        chk("nom_chien_max", 16'(max_cc), 16'(N - 1));
        chk("nom_done_cnt", 16'(n_fd), 16'd1);
        chk("nom_frame_cnt", frame_cnt, 16'd1);

        // Gapped input: one symbol every other cycle for 2N cycles.
        clear_obs();
        tog = 1'b1; auto_first = 1'b1; bm_delay = 5;
        run(2 * N);
        tog = 1'b0; vpct = 0; auto_first = 1'b0;
        run(300);
        chk("gap_scalc_cnt", 16'(n_sc), 16'd1);
        chk("gap_frame_cnt", frame_cnt, 16'd2);

        // Resync at symbol 100, then N further symbols.
        clear_obs();
        vpct = 100; auto_first = 1'b1; resync_at = 100; bm_delay = 2;
        run(99 + N);
        vpct = 0; auto_first = 1'b0;
        run(300);
        chk("resync_err_cnt", 16'(n_fe), 16'd1);
        chk("resync_scalc_cnt", 16'(n_sc), 16'd1);

        // BM timeout.
        clear_obs();
        fc_before = frame_cnt;
        vpct = 100; auto_first = 1'b1; bm_delay = 1000;
        run(N);
        vpct = 0; auto_first = 1'b0;
        run(BM_TIMEOUT + 10);
        chk("tmo_err_cnt", 16'(n_fe), 16'd1);
        chk("tmo_frame_cnt", frame_cnt, fc_before);
        chk("tmo_in_ready", 16'(in_ready), 16'd1);

        // Reset while awaiting BM, then a late BM_done.
        clear_obs();
        vpct = 100; auto_first = 1'b1; bm_delay = 10;
        run(N);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        vpct = 0; auto_first = 1'b0;
        run(20);
        chk("bmrst_chien_cnt", 16'(n_ce), 16'd0);

        // Reset mid-sweep at chien_cnt = 100.
        clear_obs();
        vpct = 100; auto_first = 1'b1; bm_delay = 3;
        run(N);
        vpct = 0; auto_first = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (m_phase == 2 && t - t_ch == 100) hit = 1'b1;
            else run(1);
        end
        chk("midchien_reached", 16'(hit), 16'd1);
        chk("midchien_cnt", 16'(chien_cnt), 16'd100);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("midchien_en", 16'(chien_en), 16'd0);
        chk("midchien_fcnt", frame_cnt, 16'd0);
        run(300);
        chk("midchien_no_done", 16'(n_fd), 16'd0);

        // Randomized traffic: gaps, rare resyncs, varied BM latency incl. timeouts, stray BM_done.
        for (int r = 0; r < 5; r++) begin
            vpct = $urandom_range(100, 50);
            bm_delay = $urandom_range(BM_TIMEOUT + 6, 0);
            rnd_resync = 300;
            stray = 1'b1; auto_first = 1'b1;
            run(900);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
